// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (I) and load/store (D).
// D normally wins; a saturating counter forces an I grant after STARVE_LIMIT back-to-back D grants.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 20,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_valid_o,
  output logic [31:0]           i_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [3:0]            d_be_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]           d_wdata_i,
  output logic                  d_valid_o,
  output logic [31:0]           d_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  stall_f_o,
  output logic                  stall_m_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int              SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]      LAT        = 4'(MEM_LATENCY);

  logic [1:0]            r_state;
  logic [3:0]            r_lat;
  logic                  r_gnt_d;
  logic [SW-1:0]         r_starve;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [3:0]            r_mem_be;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_i_valid;
  logic                  r_d_valid;
  logic [31:0]           r_i_rdata;
  logic [31:0]           r_d_rdata;

  logic w_force_i;
  logic w_pick_i;

  assign w_force_i = (STARVE_LIMIT != 0) && (r_starve == STARVE_MAX);
  assign w_pick_i  = i_req_i & (~d_req_i | w_force_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_lat       <= '0;
      r_gnt_d     <= 1'b0;
      r_starve    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_i | d_req_i) begin
            r_state  <= S_ISSUE;
            r_mem_en <= 1'b1;
            r_gnt_d  <= ~w_pick_i;
            if (w_pick_i) begin
              r_mem_addr  <= i_addr_i;
              r_mem_we    <= 1'b0;
              r_mem_be    <= 4'hF;
              r_mem_wdata <= '0;
              r_starve    <= '0;
            end else begin
              r_mem_addr  <= d_addr_i;
              r_mem_we    <= d_we_i;
              r_mem_be    <= d_we_i ? d_be_i : 4'hF;
              r_mem_wdata <= d_wdata_i;
              if (!i_req_i)
                r_starve <= '0;
              else if (r_starve != STARVE_MAX)
                r_starve <= r_starve + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_mem_en <= 1'b0;
          r_lat    <= LAT;
          r_state  <= S_WAIT;
        end
        // WAIT lasts exactly MEM_LATENCY cycles, so the exit edge is the rdata-valid edge.
        S_WAIT: begin
          if (r_lat == 4'd1) begin
            r_state <= S_DONE;
            if (r_gnt_d) begin
              r_d_valid <= 1'b1;
              if (!r_mem_we) r_d_rdata <= mem_rdata_i;
            end else begin
              r_i_valid <= 1'b1;
              r_i_rdata <= mem_rdata_i;
            end
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        S_DONE: begin
          r_i_valid <= 1'b0;
          r_d_valid <= 1'b0;
          r_mem_we  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_en_o    = r_mem_en;
  assign mem_we_o    = r_mem_we;
  assign mem_be_o    = r_mem_be;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign i_valid_o   = r_i_valid;
  assign i_rdata_o   = r_i_rdata;
  assign d_valid_o   = r_d_valid;
  assign d_rdata_o   = r_d_rdata;
  assign stall_f_o   = i_req_i & ~r_i_valid;
  assign stall_m_o   = d_req_i & ~r_d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four builds (default, latency 1, latency 15, starvation guard off)
// checked every cycle against a transaction-schedule model, plus literal directed expectations.
module tb_mem_port_arbiter;
  localparam int NI = 4;
  localparam int AW = 20;

  function automatic int lat_of(int k);
    return (k == 1) ? 1 : (k == 2) ? 15 : 2;
  endfunction
  function automatic int sl_of(int k);
    return (k == 3) ? 0 : 4;
  endfunction
  function automatic logic [31:0] init_word(int w);
    return (w == 4) ? 32'h00500093 : (32'h11000000 | 32'(w * 4));
  endfunction
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [NI-1:0] i_req, d_req, d_we, i_valid, d_valid, mem_en, mem_we, stall_f, stall_m;
  logic [3:0]    d_be [NI];
  logic [3:0]    mem_be [NI];
  logic [AW-1:0] i_addr [NI];
  logic [AW-1:0] d_addr [NI];
  logic [AW-1:0] mem_addr [NI];
  logic [31:0]   d_wdata [NI];
  logic [31:0]   i_rdata [NI];
  logic [31:0]   d_rdata [NI];
  logic [31:0]   mem_wdata [NI];
  logic [31:0]   mem_rdata [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(lat_of(g)), .STARVE_LIMIT(sl_of(g))) u_dut (
      .clk_i(clk), .rst_i(rst_n),
      .i_req_i(i_req[g]), .i_addr_i(i_addr[g]), .i_valid_o(i_valid[g]), .i_rdata_o(i_rdata[g]),
      .d_req_i(d_req[g]), .d_we_i(d_we[g]), .d_be_i(d_be[g]), .d_addr_i(d_addr[g]),
      .d_wdata_i(d_wdata[g]), .d_valid_o(d_valid[g]), .d_rdata_o(d_rdata[g]),
      .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_be_o(mem_be[g]), .mem_addr_o(mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g]),
      .stall_f_o(stall_f[g]), .stall_m_o(stall_m[g])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Memory: read data is present only in the cycle MEM_LATENCY after mem_en, garbage otherwise.
  logic [31:0]   emem [NI][256];
  int            rcnt [NI];
  logic [AW-1:0] raddr [NI];
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      mem_rdata[k] = 32'hBAD0BAD0;
      if (!rst_n) rcnt[k] = 0;
      else if (mem_en[k]) begin
        raddr[k] = mem_addr[k];
        rcnt[k]  = mem_we[k] ? 0 : lat_of(k);
        if (mem_we[k])
          emem[k][mem_addr[k][9:2]] = merge(emem[k][mem_addr[k][9:2]], mem_wdata[k], mem_be[k]);
      end else if (rcnt[k] > 0) begin
        rcnt[k]--;
        if (rcnt[k] == 0) mem_rdata[k] = emem[k][raddr[k][9:2]];
      end
    end
  end

  // Model: a granted access is a schedule (mem_en at grant+1, valid at grant+2+L, idle after).
  bit            busy [NI];
  int            t_en [NI];
  int            t_val [NI];
  int            starve [NI];
  bit            m_d [NI];
  bit            m_we [NI];
  logic [AW-1:0] m_addr [NI];
  logic [3:0]    m_be [NI];
  logic [31:0]   m_wd [NI];
  logic [31:0]   m_rd [NI];
  logic [31:0]   e_ird [NI];
  logic [31:0]   e_drd [NI];
  logic [31:0]   mmem [NI][256];
  int            en_cyc [NI];
  logic [AW-1:0] en_addr [NI];
  logic          en_we [NI];
  logic [3:0]    en_be [NI];
  bit            glog [NI][$];
  logic          e_en, e_done, pick_i;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        busy[k] = 0; starve[k] = 0; e_ird[k] = '0; e_drd[k] = '0;
        chk($sformatf("rst_ctl[%0d]", k),
            {mem_en[k], mem_we[k], i_valid[k], d_valid[k], mem_be[k], mem_addr[k]}, 64'h0);
        chk($sformatf("rst_rdata[%0d]", k), {i_rdata[k], d_rdata[k]}, 64'h0);
        chk($sformatf("rst_wdata[%0d]", k), mem_wdata[k], 64'h0);
      end else begin
        e_en   = busy[k] && (cyc == t_en[k]);
        e_done = busy[k] && (cyc == t_val[k]);
        if (e_done && !m_we[k]) begin
          if (m_d[k]) e_drd[k] = m_rd[k];
          else        e_ird[k] = m_rd[k];
        end
        chk($sformatf("mem_en[%0d]", k), mem_en[k], e_en);
        chk($sformatf("i_valid[%0d]", k), i_valid[k], e_done && !m_d[k]);
        chk($sformatf("d_valid[%0d]", k), d_valid[k], e_done && m_d[k]);
        chk($sformatf("i_rdata[%0d]", k), i_rdata[k], e_ird[k]);
        chk($sformatf("d_rdata[%0d]", k), d_rdata[k], e_drd[k]);
        chk($sformatf("stall_f[%0d]", k), stall_f[k], i_req[k] && !(e_done && !m_d[k]));
        chk($sformatf("stall_m[%0d]", k), stall_m[k], d_req[k] && !(e_done && m_d[k]));
        if (e_en)
          chk($sformatf("mem_req[%0d]", k),
              {mem_addr[k], mem_we[k], mem_be[k], mem_we[k] ? mem_wdata[k] : 32'h0},
              {m_addr[k], m_we[k], m_be[k], m_we[k] ? m_wd[k] : 32'h0});
        if (mem_en[k]) begin
          en_cyc[k] = cyc; en_addr[k] = mem_addr[k]; en_we[k] = mem_we[k]; en_be[k] = mem_be[k];
        end
        if (i_valid[k]) glog[k].push_back(1'b0);
        if (d_valid[k]) glog[k].push_back(1'b1);
        if (e_done) busy[k] = 0;
        else if (!busy[k] && (i_req[k] || d_req[k])) begin
          pick_i = i_req[k] && (!d_req[k] || (sl_of(k) != 0 && starve[k] == sl_of(k)));
          busy[k] = 1; t_en[k] = cyc + 1; t_val[k] = cyc + 2 + lat_of(k); m_d[k] = !pick_i;
          if (pick_i) begin
            m_addr[k] = i_addr[k]; m_we[k] = 0; m_be[k] = 4'hF; m_wd[k] = '0; starve[k] = 0;
          end else begin
            m_addr[k] = d_addr[k]; m_we[k] = d_we[k]; m_be[k] = d_we[k] ? d_be[k] : 4'hF;
            m_wd[k] = d_wdata[k];
            starve[k] = !i_req[k] ? 0 : (starve[k] < sl_of(k)) ? starve[k] + 1 : starve[k];
          end
          if (m_we[k]) mmem[k][m_addr[k][9:2]] = merge(mmem[k][m_addr[k][9:2]], m_wd[k], m_be[k]);
          else         m_rd[k] = mmem[k][m_addr[k][9:2]];
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int k, input bit d, input int c0, input int budget,
                            output int lat, output int sc);
    lat = -1;
    sc  = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (d ? stall_m[k] : stall_f[k]) sc++;
      if (d ? d_valid[k] : i_valid[k]) begin
        lat = cyc - c0;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout[%0d] actual=no valid required=valid within %0d cycles", k, budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int lat, sc, c0, nv, ni;
    logic [5:0] gseq;
    i_req = '0; d_req = '0; d_we = '0;
    for (int k = 0; k < NI; k++) begin
      d_be[k] = '0; i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
      busy[k] = 0; rcnt[k] = 0; en_cyc[k] = 0;
      for (int w = 0; w < 256; w++) begin
        emem[k][w] = init_word(w);
        mmem[k][w] = init_word(w);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {mem_en[0], i_valid[0], d_valid[0], mem_be[0], mem_addr[0]}, 64'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // single fetch
    c0 = cyc; i_addr[0] = 20'h00010; i_req[0] = 1'b1;
    wait_valid(0, 0, c0, 20, lat, sc);
    chk("fetch_lat", lat, 4);
    chk("fetch_rdata", i_rdata[0], 32'h00500093);
    chk("fetch_stall_cycles", sc, 4);
    chk("fetch_en_cycle", en_cyc[0] - c0, 1);
    chk("fetch_en_addr", en_addr[0], 20'h00010);
    next_cycle(); i_req[0] = 1'b0;

    // load, store with partial byte enables, load back
    c0 = cyc; d_addr[0] = 20'h00104; d_we[0] = 1'b0; d_req[0] = 1'b1;
    wait_valid(0, 1, c0, 20, lat, sc);
    chk("load_rdata", d_rdata[0], 32'h11000104);
    next_cycle();
    c0 = cyc; d_we[0] = 1'b1; d_be[0] = 4'b0011; d_wdata[0] = 32'hDEADBEEF;
    wait_valid(0, 1, c0, 20, lat, sc);
    chk("store_lat", lat, 4);
    chk("store_we_be", {en_we[0], en_be[0]}, 5'b1_0011);
    chk("store_rdata_kept", d_rdata[0], 32'h11000104);
    next_cycle(); d_we[0] = 1'b0;
    c0 = cyc;
    wait_valid(0, 1, c0, 20, lat, sc);
    chk("load_back", d_rdata[0], 32'h1100BEEF);
    next_cycle(); d_req[0] = 1'b0;

    // simultaneous I and D: D first
    c0 = cyc; i_addr[0] = 20'h00020; d_addr[0] = 20'h00200; i_req[0] = 1'b1; d_req[0] = 1'b1;
    wait_valid(0, 1, c0, 20, lat, sc);
    chk("both_d_lat", lat, 4);
    chk("both_d_rdata", d_rdata[0], 32'h11000200);
    next_cycle(); d_req[0] = 1'b0;
    wait_valid(0, 0, c0, 20, lat, sc);
    chk("both_i_lat", lat, 9);
    chk("both_i_rdata", i_rdata[0], 32'h11000020);
    next_cycle(); i_req[0] = 1'b0;

    // starvation guard at limit 4
    glog[0].delete();
    d_addr[0] = 20'h00300; i_addr[0] = 20'h00040; d_req[0] = 1'b1; i_req[0] = 1'b1;
    for (int n = 0; n < 60 && glog[0].size() < 6; n++) begin
      @(negedge clk); #1;
      nv = i_valid[0];
      next_cycle();
      if (nv != 0) i_req[0] = 1'b0;
    end
    d_req[0] = 1'b0; i_req[0] = 1'b0;
    gseq = '0;
    for (int j = 0; j < 6 && j < glog[0].size(); j++) gseq = {gseq[4:0], glog[0][j]};
    chk("starve_grants", glog[0].size(), 6);
    chk("starve_order", gseq, 6'b111101);
    chk("starve_i_rdata", i_rdata[0], 32'h11000040);
    next_cycle();

    // guard disabled: I waits for as long as D is asserted
    glog[3].delete();
    d_addr[3] = 20'h00300; i_addr[3] = 20'h00040; d_req[3] = 1'b1; i_req[3] = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    ni = 0;
    foreach (glog[3][j]) if (!glog[3][j]) ni++;
    chk("noguard_i_grants", ni, 0);
    chk("noguard_d_grants", glog[3].size(), 8);
    next_cycle(); d_req[3] = 1'b0;
    c0 = cyc;
    wait_valid(3, 0, c0, 20, lat, sc);
    chk("noguard_i_lat", lat, 4);
    chk("noguard_i_rdata", i_rdata[3], 32'h11000040);
    next_cycle(); i_req[3] = 1'b0;

    // reset in WAIT abandons the access
    i_addr[0] = 20'h00030; i_req[0] = 1'b1;
    next_cycle(); next_cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_en", mem_en[0], 1'b0);
    chk("midrst_valids", {i_valid[0], d_valid[0]}, 2'b00);
    chk("midrst_rdata", i_rdata[0], 32'h0);
    chk("midrst_addr", mem_addr[0], 20'h0);
    i_req[0] = 1'b0;
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (i_valid[0] || d_valid[0]) nv++;
    end
    chk("midrst_no_valid", nv, 0);
    next_cycle();
    c0 = cyc; i_addr[0] = 20'h00010; i_req[0] = 1'b1;
    wait_valid(0, 0, c0, 20, lat, sc);
    chk("postrst_lat", lat, 4);
    chk("postrst_rdata", i_rdata[0], 32'h00500093);
    next_cycle(); i_req[0] = 1'b0;

    // latency extremes
    c0 = cyc; i_addr[1] = 20'h00010; i_req[1] = 1'b1;
    wait_valid(1, 0, c0, 30, lat, sc);
    chk("lat1_lat", lat, 3);
    chk("lat1_rdata", i_rdata[1], 32'h00500093);
    next_cycle(); i_req[1] = 1'b0;
    c0 = cyc; d_addr[2] = 20'h00020; d_req[2] = 1'b1;
    wait_valid(2, 1, c0, 30, lat, sc);
    chk("lat15_lat", lat, 17);
    chk("lat15_rdata", d_rdata[2], 32'h11000020);
    next_cycle(); d_req[2] = 1'b0;

    next_cycle(); next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
